// File: rtl/debounce_defs.sv
// Shared state encoding for the button debouncer channels.
// Benches can reference these names to probe per-channel state.
package debounce_defs;

  typedef enum logic [1:0] {
    LOW       = 2'b00,
    WAIT_HIGH = 2'b01,
    HIGH      = 2'b10,
    WAIT_LOW  = 2'b11
  } db_state_e;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: two-flop synchronizer, stable-time counter and
// 4-state FSM producing a registered level plus rise/fall strobes.
module debounce_channel
  import debounce_defs::*;
#(
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic level,
  output logic rise,
  output logic fall
);

  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int               CNT_W    = cnt_width(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             s1;
  logic             s2;
  db_state_e        state;
  db_state_e        state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             level_next;
  logic             rise_next;
  logic             fall_next;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      state <= LOW;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      s1    <= btn;
      s2    <= s1;
      state <= state_next;
      cnt   <= cnt_next;
      level <= level_next;
      rise  <= rise_next;
      fall  <= fall_next;
    end
  end

  // Any opposite sample while waiting returns to the origin state, so a
  // partial count is discarded and the next attempt restarts from zero.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    level_next = level;
    rise_next  = 1'b0;
    fall_next  = 1'b0;
    case (state)
      LOW: begin
        if (s2) begin
          state_next = WAIT_HIGH;
          cnt_next   = '0;
        end
      end
      WAIT_HIGH: begin
        if (!s2) begin
          state_next = LOW;
        end else if (cnt == CNT_LAST) begin
          state_next = HIGH;
          cnt_next   = '0;
          level_next = 1'b1;
          rise_next  = 1'b1;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      HIGH: begin
        if (!s2) begin
          state_next = WAIT_LOW;
          cnt_next   = '0;
        end
      end
      WAIT_LOW: begin
        if (s2) begin
          state_next = HIGH;
        end else if (cnt == CNT_LAST) begin
          state_next = LOW;
          cnt_next   = '0;
          level_next = 1'b0;
          fall_next  = 1'b1;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_next = LOW;
        cnt_next   = '0;
      end
    endcase
  end

endmodule

// File: rtl/button_debouncer.sv
// Multi-channel push-button conditioner: N_BTN independent debounce
// channels whose outputs are concatenated into bit vectors.
module button_debouncer #(
  parameter int N_BTN     = 5,
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic             i_CLK,
  input  logic             i_RST_N,
  input  logic [N_BTN-1:0] i_BTN,
  output logic [N_BTN-1:0] o_LEVEL,
  output logic [N_BTN-1:0] o_RISE,
  output logic [N_BTN-1:0] o_FALL
);

  for (genvar n = 0; n < N_BTN; n++) begin : g_ch
    debounce_channel #(
      .DB_CYCLES(DB_CYCLES)
    ) u_ch (
      .clk  (i_CLK),
      .rst_n(i_RST_N),
      .btn  (i_BTN[n]),
      .level(o_LEVEL[n]),
      .rise (o_RISE[n]),
      .fall (o_FALL[n])
    );
  end

endmodule

// File: doc/button_debouncer.md
# button_debouncer

Multi-channel push-button conditioner for the board's raw button inputs. It synchronizes each asynchronous button pin into the `i_CLK` domain and filters contact bounce with a per-channel stable-time counter. It then presents a clean level plus single-cycle rise/fall strobes. It sits directly upstream of `button_tick_latch`: each `o_LEVEL` bit drives that block's `i_BTN`, or `o_RISE` is consumed directly where a tick is needed.

## Interface
- `N_BTN`, default 5: number of independent button channels.
- `DB_CYCLES`, default 1_000_000 (10 ms at 100 MHz): consecutive stable cycles required to accept a new level. Legal range is ≥1.
- `i_CLK`, in, 1: system clock. All logic updates on the rising edge.
- `i_RST_N`, in, 1: reset, synchronous and active-low.
- `i_BTN`, in, `N_BTN`: raw, asynchronous, bouncing button pins. Active-high.
- `o_LEVEL`, out, `N_BTN`: debounced button level, registered.
- `o_RISE`, out, `N_BTN`: one-cycle pulse when `o_LEVEL` bit goes 0→1.
- `o_FALL`, out, `N_BTN`: one-cycle pulse when `o_LEVEL` bit goes 1→0.

## Operation
- Each channel is fully independent. There is no cross-channel interaction or priority.
- Synchronizer: two flip-flops per bit, `s1 <= i_BTN[n]`, `s2 <= s1`. The FSM uses only `s2`.
- Counter: `cnt` is `$clog2(DB_CYCLES)` bits wide, minimum 1 bit. It never wraps; it is cleared before it can exceed `DB_CYCLES-1`.
- Per-channel FSM, 4 states:
  - `LOW`: `o_LEVEL`=0. If `s2`=1, go to `WAIT_HIGH` and set `cnt`=0.
  - `WAIT_HIGH`:
    - If `s2`=0, return to `LOW` with no output activity (bounce rejected).
    - Else if `cnt`==`DB_CYCLES`-1, go to `HIGH`, set `o_LEVEL`=1, and pulse `o_RISE`.
    - Else increment `cnt`.
  - `HIGH`: `o_LEVEL`=1. If `s2`=0, go to `WAIT_LOW` and set `cnt`=0.
  - `WAIT_LOW`:
    - If `s2`=1, return to `HIGH` with no output activity.
    - Else if `cnt`==`DB_CYCLES`-1, go to `LOW`, set `o_LEVEL`=0, and pulse `o_FALL`.
    - Else increment `cnt`.
- `o_LEVEL` holds its old value throughout both `WAIT_*` states.
- `o_RISE` and `o_FALL` are registered. For a given bit they are never high in the same cycle.

## Timing
- Reset values, applied on any `i_RST_N`=0 sampled edge:
  - `s1`, `s2`, `cnt`: 0.
  - State: `LOW`.
  - `o_LEVEL`, `o_RISE`, `o_FALL`: 0.
- Press latency: count the edge that first samples `i_BTN[n]`=1 as edge 1. If the input is held stable, `o_LEVEL[n]` and `o_RISE[n]` go high after edge `DB_CYCLES`+3. `o_RISE[n]` drops after edge `DB_CYCLES`+4.
- Release latency: symmetric, with `o_FALL`.
- Rejected bounce: any opposite sample of `s2` during `WAIT_*` returns to the origin state. The next qualifying sample restarts `cnt` at 0; partial counts never accumulate.
- Pulse shorter than `DB_CYCLES`+1 cycles at `s2`: no output change.
- `DB_CYCLES`=1: press latency is exactly 4 edges.
- Reset mid-`WAIT_*` or mid-pulse: the channel returns to `LOW` immediately and any pending strobe is dropped. If the button is still held when reset releases, it is re-debounced and `o_RISE` fires normally.
- Holding reset for a single cycle is sufficient.

## Structure
- Sub-module `debounce_channel`: one synchronizer, counter and FSM for one bit, with the same clock, reset and `DB_CYCLES`. `button_debouncer` instantiates `N_BTN` copies in a generate loop and concatenates the outputs.
- The state encoding (`LOW`, `WAIT_HIGH`, `HIGH`, `WAIT_LOW`, 2 bits) lives in a shared `debounce_defs` package/header so benches can probe state by name.
- The counter-width function lives in `debounce_channel`.

## Test plan
All scenarios use `DB_CYCLES`=4 and `N_BTN`=5.
- Reset: drive `i_RST_N`=0 for 1 edge with `i_BTN`=5'b11111. All outputs are 0 during reset. After release, `o_LEVEL`=5'b11111 appears after edge 7 with a single `o_RISE`=5'b11111 cycle.
- Clean press/release on bit 0: hold 20 cycles, then release. `o_LEVEL[0]` rises after edge 7 and falls 7 edges after the first low sample. Exactly one `o_RISE[0]` and one `o_FALL[0]` pulse occur.
- Bounce: on bit 2, toggle the input 1-2-1-3 cycles high/low, then hold high. Outputs stay 0 until 7 edges after the final stable-high sample, and exactly one `o_RISE[2]` occurs.
- Short glitch: hold bit 3 high for 3 cycles only. `o_LEVEL[3]`, `o_RISE[3]` and `o_FALL[3]` stay 0.
- Mid-wait reset: press bit 1, assert reset at edge 5. No `o_RISE[1]` is produced before reset. After release with the button held, `o_RISE[1]` fires 7 edges later.
- Channel independence: press bits 0 and 4 offset by 2 cycles. The `o_RISE` pulses are also offset by 2 cycles, and the other bits remain 0.
